// File: rtl/seq_divider_pkg.sv
// seq_divider_pkg: state encoding and sizing shared by the divider and its step cell.
package seq_divider_pkg;
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;
  localparam int DEF_WIDTH = 16;
  function automatic int cnt_width(int w);
    return $clog2(w);
  endfunction
  localparam int DEF_CNT_W = cnt_width(DEF_WIDTH);
endpackage

// File: rtl/seq_divider_div_step.sv
// div_step: one restoring-division step, shift in a dividend bit then trial-subtract the divisor.
module div_step
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] dvs_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_o
);
  logic [WIDTH+1:0] sh;
  logic [WIDTH+1:0] diff;
  always_comb begin
    sh    = {rem_i, bit_i};
    diff  = sh - {2'b00, dvs_i};
    q_o   = ~diff[WIDTH+1];
    rem_o = q_o ? diff[WIDTH:0] : sh[WIDTH:0];
  end
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider, signed/unsigned, one quotient bit per clock.
module seq_divider
  import seq_divider_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  localparam int CW = cnt_width(WIDTH);
  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH:0]   rem_q, rem_d, rem_nx;
  logic [WIDTH-1:0] quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] quotient_q, quotient_d, remainder_q, remainder_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d, dbz_q, dbz_d;
  logic             q_bit, go;

  // quo_q doubles as the dividend shift register: its MSB feeds the step, the new quotient bit enters at the LSB
  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i(rem_q),
    .bit_i(quo_q[WIDTH-1]),
    .dvs_i(dvs_q),
    .rem_o(rem_nx),
    .q_o  (q_bit)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    qneg_d      = qneg_q;
    rneg_d      = rneg_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    dbz_d       = dbz_q;
    go          = start & (state_q == IDLE || state_q == DONE);
    if (go && divisor == '0) begin
      state_d     = DONE;
      quotient_d  = '1;
      remainder_d = dividend;
      dbz_d       = 1'b1;
    end else if (go) begin
      state_d = RUN;
      quo_d   = (signed_op & dividend[WIDTH-1]) ? -dividend : dividend;
      dvs_d   = (signed_op & divisor[WIDTH-1]) ? -divisor : divisor;
      qneg_d  = signed_op & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
      rneg_d  = signed_op & dividend[WIDTH-1];
      rem_d   = '0;
      cnt_d   = CW'(WIDTH - 1);
    end else if (state_q == RUN) begin
      rem_d   = rem_nx;
      quo_d   = {quo_q[WIDTH-2:0], q_bit};
      cnt_d   = cnt_q - CW'(1);
      state_d = (cnt_q == '0) ? FIX : RUN;
    end else if (state_q == FIX) begin
      quotient_d  = qneg_q ? -quo_q : quo_q;
      remainder_d = rneg_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
      dbz_d       = 1'b0;
      state_d     = DONE;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      qneg_q      <= 1'b0;
      rneg_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      qneg_q      <= qneg_d;
      rneg_q      <= rneg_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      dbz_q       <= dbz_d;
    end
  end

  assign busy        = (state_q == RUN) || (state_q == FIX);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = dbz_q;
endmodule
